// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I core.
//   - write-back source select codes (in_wb_sel)
//   - load funct3 codes
//   - MEM/WB stage FSM state encoding
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load data alignment and extension.
// Ports:
//   funct3     in  3   load width/sign code
//   off        in  2   byte offset within the word (address bits [1:0])
//   rdata      in  32  raw little-endian word from data memory
//   load_data  out 32  aligned, sign- or zero-extended value
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0] sb;
        sb = b;
        if (sgn) begin
            ext_byte = 32'(sb);
        end else begin
            ext_byte = {24'd0, b};
        end
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        sh = h;
        if (sgn) begin
            ext_half = 32'(sh);
        end else begin
            ext_half = {16'd0, h};
        end
    endfunction

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[8*off +: 8];
        // Halfword loads ignore off[0]: misaligned halves read the containing half.
        sel_half = rdata[16*off[1] +: 16];
        unique case (funct3)
            F3_LB:   load_data = ext_byte(sel_byte, 1'b1);
            F3_LBU:  load_data = ext_byte(sel_byte, 1'b0);
            F3_LH:   load_data = ext_half(sel_half, 1'b1);
            F3_LHU:  load_data = ext_half(sel_half, 1'b0);
            // LW and undefined codes deliver the full word.
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage of the RV32I core.
// Registers the instruction leaving MEM, waits for load data, aligns it,
// selects the write-back value, drives the register file write port,
// requests a stall while a load is outstanding and counts retirements.
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   in_valid .. in_pc_plus4 instruction fields from MEM
//   dmem_rvalid, dmem_rdata load response from data memory
//   stall_req              hold MEM and earlier stages
//   regwrite, write_reg, write_data  register file write port
//   wb_valid               an instruction retires this cycle
//   instret                64-bit retired-instruction counter
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic            in_regwrite,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_req,
    output logic            regwrite,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic            wb_valid,
    output logic [63:0]     instret
);

    wb_state_e       state_q, state_d;
    logic            valid_q, valid_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      wb_sel_q, wb_sel_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [63:0]     instret_q, instret_d;

    logic            cap;
    logic [31:0]     load_data;

    load_align u_load_align (
        .funct3    (funct3_q),
        .off       (alu_q[1:0]),
        .rdata     (dmem_rdata),
        .load_data (load_data)
    );

    // Stall and retire depend only on state and the memory response, never on in_*,
    // so there is no combinational path from MEM back into MEM's hold signal.
    always_comb begin
        stall_req = 1'b0;
        wb_valid  = 1'b0;
        unique case (state_q)
            ST_WAIT_LOAD: begin
                stall_req = ~dmem_rvalid;
                wb_valid  = dmem_rvalid;
            end
            default: begin
                wb_valid = valid_q & (wb_sel_q != WB_LOAD);
            end
        endcase
        cap = ~stall_req;
    end

    always_comb begin
        regwrite  = wb_valid & regwrite_q & (rd_q != 5'd0);
        write_reg = rd_q;
        unique case (wb_sel_q)
            WB_LOAD: write_data = load_data;
            WB_PC4:  write_data = pc4_q;
            default: write_data = alu_q;
        endcase
        instret = instret_q;
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        wb_sel_d   = wb_sel_q;
        funct3_d   = funct3_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        instret_d  = instret_q + {63'd0, wb_valid};

        // A returning load frees the stage in the same cycle, so the next
        // instruction is captured without a bubble.
        if (cap) begin
            valid_d    = in_valid;
            regwrite_d = in_regwrite;
            rd_d       = in_rd;
            wb_sel_d   = in_wb_sel;
            funct3_d   = in_funct3;
            alu_d      = in_alu_result;
            pc4_d      = in_pc_plus4;
            state_d    = (in_valid && in_wb_sel == WB_LOAD) ? ST_WAIT_LOAD : ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wb_sel_q   <= 2'b00;
            funct3_q   <= 3'd0;
            alu_q      <= '0;
            pc4_q      <= '0;
            instret_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wb_sel_q   <= wb_sel_d;
            funct3_q   <= funct3_d;
            alu_q      <= alu_d;
            pc4_q      <= pc4_d;
            instret_q  <= instret_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_req;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        wb_valid;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_wb_stage #(.XLEN(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_regwrite   (in_regwrite),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .stall_req     (stall_req),
        .regwrite      (regwrite),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .wb_valid      (wb_valid),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4);
        in_valid      = v;
        in_regwrite   = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_funct3     = f3;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
    endtask

    initial begin
        reset_n     = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #12;
        check("rst_stall", {63'd0, stall_req}, 64'd0);
        check("rst_regwrite", {63'd0, regwrite}, 64'd0);
        check("rst_write_reg", {59'd0, write_reg}, 64'd0);
        check("rst_write_data", {32'd0, write_data}, 64'd0);
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_instret", instret, 64'd0);
        reset_n = 1'b1;
        tick();

        // ALU op to x5
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'd0, 32'h1234, 32'h100);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #1;
        check("alu_regwrite", {63'd0, regwrite}, 64'd1);
        check("alu_write_reg", {59'd0, write_reg}, 64'd5);
        check("alu_write_data", {32'd0, write_data}, 64'h1234);
        check("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("alu_instret_before", instret, 64'd0);
        tick();
        check("alu_instret_after", instret, 64'd1);
        check("bubble_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("bubble_regwrite", {63'd0, regwrite}, 64'd0);

        // LB, rvalid two cycles after capture
        drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b000, 32'h0000_1003, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #1;
        check("lb_stall", {63'd0, stall_req}, 64'd1);
        check("lb_wait_wb_valid", {63'd0, wb_valid}, 64'd0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_0000;
        #1;
        check("lb_rv_stall", {63'd0, stall_req}, 64'd0);
        check("lb_rv_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("lb_rv_regwrite", {63'd0, regwrite}, 64'd1);
        check("lb_rv_write_reg", {59'd0, write_reg}, 64'd7);
        check("lb_data", {32'd0, write_data}, 64'hFFFF_FF80);
        tick();
        dmem_rvalid = 1'b0;
        check("lb_instret", instret, 64'd2);

        // LBU, same inputs
        drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b100, 32'h0000_1003, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #1;
        check("lbu_stall", {63'd0, stall_req}, 64'd1);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_0000;
        #1;
        check("lbu_data", {32'd0, write_data}, 64'h0000_0080);
        tick();
        dmem_rvalid = 1'b0;

        // LHU at offset 2, rvalid one cycle after capture
        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b101, 32'h0000_2002, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBEEF_1234;
        #1;
        check("lhu_data", {32'd0, write_data}, 64'h0000_BEEF);
        check("lhu_stall", {63'd0, stall_req}, 64'd0);
        tick();
        dmem_rvalid = 1'b0;

        // LH at offset 3 (off[0] ignored)
        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b001, 32'h0000_2003, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBEEF_1234;
        #1;
        check("lh_data", {32'd0, write_data}, 64'hFFFF_BEEF);
        tick();
        dmem_rvalid = 1'b0;
        check("loads_instret", instret, 64'd5);

        // PC+4 write to x0
        drive(1'b1, 1'b1, 5'd0, 2'b10, 3'd0, 32'h999, 32'h44);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #1;
        check("x0_regwrite", {63'd0, regwrite}, 64'd0);
        check("x0_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("x0_write_data", {32'd0, write_data}, 64'h44);
        tick();
        check("x0_instret", instret, 64'd6);

        // Back-to-back: LW then ALU op captured in the rvalid cycle
        drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b010, 32'h0000_3000, 32'd0);
        tick();
        drive(1'b1, 1'b1, 5'd10, 2'b00, 3'd0, 32'h55, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_BABE;
        #1;
        check("b2b_lw_data", {32'd0, write_data}, 64'hCAFE_BABE);
        check("b2b_lw_reg", {59'd0, write_reg}, 64'd9);
        check("b2b_lw_stall", {63'd0, stall_req}, 64'd0);
        tick();
        dmem_rvalid = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #1;
        check("b2b_alu_regwrite", {63'd0, regwrite}, 64'd1);
        check("b2b_alu_reg", {59'd0, write_reg}, 64'd10);
        check("b2b_alu_data", {32'd0, write_data}, 64'h55);
        check("b2b_instret_mid", instret, 64'd7);
        tick();
        check("b2b_instret_end", instret, 64'd8);

        // Spurious rvalid while idle
        dmem_rvalid = 1'b1;
        #1;
        check("spur_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("spur_stall", {63'd0, stall_req}, 64'd0);
        tick();
        dmem_rvalid = 1'b0;
        check("spur_instret", instret, 64'd8);

        // Reset while waiting for a load, then a late rvalid
        drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b010, 32'h0000_4000, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0);
        #1;
        check("rw_stall_before", {63'd0, stall_req}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rw_stall_in_reset", {63'd0, stall_req}, 64'd0);
        check("rw_instret_in_reset", instret, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        #1;
        check("rw_late_regwrite", {63'd0, regwrite}, 64'd0);
        check("rw_late_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rw_late_stall", {63'd0, stall_req}, 64'd0);
        tick();
        dmem_rvalid = 1'b0;
        check("rw_instret", instret, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
